// File: rtl/ptp_perout_gen.sv
// Periodic output aligned to absolute PTP time (start, period, width), for PPS and other rates.
// Latency: 2 clk from a qualifying ts_96 value at the input to the perout change.
// Backpressure: none; ts_96 is sampled every cycle and cfg_valid is a single-cycle strobe.
module ptp_perout_gen #(
    parameter int FNS_W        = 16,
    parameter bit OUT_POLARITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [95:0] ts_96,
    input  logic        enable,
    input  logic        cfg_valid,
    input  logic [79:0] cfg_start,
    input  logic [79:0] cfg_period,
    input  logic [79:0] cfg_width,
    output logic        perout,
    output logic        locked,
    output logic        cfg_error
);

    localparam logic [32:0] NS_PER_SEC = 33'd1_000_000_000;

    typedef enum logic [1:0] {IDLE, ARMED, HIGH} state_t;

    state_t      state;
    logic [79:0] ts_now;
    logic [79:0] ts_prev;
    logic [79:0] start_q;
    logic [79:0] period_q;
    logic [79:0] width_q;
    logic [79:0] next_rise;
    logic [79:0] next_fall;
    logic [79:0] rise_next;
    logic [79:0] fall_next;
    logic        cfg_held;
    logic        pulse;
    logic        cfg_legal;
    logic        back_step;
    logic        unused_fns;

    // Time sum of two {sec, ns} values; seconds wrap modulo 2^48.
    function automatic logic [79:0] t_add(input logic [79:0] a, input logic [79:0] b);
        logic [32:0] ns_sum;
        logic [47:0] sec;
        ns_sum = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        sec    = a[79:32] + b[79:32];
        if (ns_sum >= NS_PER_SEC) begin
            ns_sum = ns_sum - NS_PER_SEC;
            sec    = sec + 48'd1;
        end
        return {sec, ns_sum[31:0]};
    endfunction

    assign unused_fns = ^ts_96[FNS_W-1:0];
    assign rise_next  = t_add(next_rise, period_q);
    assign fall_next  = t_add(next_rise, width_q);
    assign cfg_legal  = (cfg_period != 80'd0) && (cfg_width != 80'd0) && (cfg_width < cfg_period);
    assign back_step  = ts_now < ts_prev;
    assign perout     = OUT_POLARITY ? pulse : ~pulse;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ts_now    <= '0;
            ts_prev   <= '0;
            start_q   <= '0;
            period_q  <= '0;
            width_q   <= '0;
            next_rise <= '0;
            next_fall <= '0;
            cfg_held  <= 1'b0;
            pulse     <= 1'b0;
            locked    <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            ts_now  <= ts_96[95 -: 80];
            ts_prev <= ts_now;
            if (cfg_valid) begin
                pulse  <= 1'b0;
                locked <= 1'b0;
                if (cfg_legal) begin
                    cfg_error <= 1'b0;
                    cfg_held  <= 1'b1;
                    start_q   <= cfg_start;
                    period_q  <= cfg_period;
                    width_q   <= cfg_width;
                    next_rise <= cfg_start;
                    state     <= enable ? ARMED : IDLE;
                end else begin
                    cfg_error <= 1'b1;
                    cfg_held  <= 1'b0;
                    start_q   <= '0;
                    period_q  <= '0;
                    width_q   <= '0;
                    next_rise <= '0;
                    next_fall <= '0;
                    state     <= IDLE;
                end
            end else if (!enable) begin
                state  <= IDLE;
                pulse  <= 1'b0;
                locked <= 1'b0;
            end else if (state != IDLE && back_step) begin
                // Time went backwards: rebuild the schedule from the start time.
                pulse     <= 1'b0;
                locked    <= 1'b0;
                next_rise <= start_q;
                state     <= ARMED;
            end else begin
                case (state)
                    IDLE: begin
                        pulse  <= 1'b0;
                        locked <= 1'b0;
                        if (cfg_held) begin
                            next_rise <= start_q;
                            state     <= ARMED;
                        end
                    end
                    ARMED: begin
                        pulse <= 1'b0;
                        if (ts_now >= rise_next) begin
                            // Whole period already missed: skip one period per cycle.
                            next_rise <= rise_next;
                            locked    <= 1'b0;
                        end else if (ts_now >= next_rise) begin
                            pulse     <= 1'b1;
                            next_fall <= fall_next;
                            next_rise <= rise_next;
                            locked    <= 1'b1;
                            state     <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (ts_now >= next_fall) begin
                            pulse <= 1'b0;
                            state <= ARMED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ptp_perout_gen.sv
// Directed bench for ptp_perout_gen: PPS, ns carry, illegal config, jumps, reset, enable drop.
module tb_ptp_perout_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] ts_96;
    logic        enable;
    logic        cfg_valid;
    logic [79:0] cfg_start;
    logic [79:0] cfg_period;
    logic [79:0] cfg_width;
    logic        perout;
    logic        locked;
    logic        cfg_error;

    int total = 0;
    int bad   = 0;

    ptp_perout_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ts_96      (ts_96),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_start  (cfg_start),
        .cfg_period (cfg_period),
        .cfg_width  (cfg_width),
        .perout     (perout),
        .locked     (locked),
        .cfg_error  (cfg_error)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] t(input logic [47:0] s, input logic [31:0] n);
        return {s, n};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one ts value for one clock; outputs are read 1 ns after the edge.
    task automatic adv(input logic [79:0] tv);
        ts_96 = {tv, 16'hA5C3};
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [79:0] st, input logic [79:0] per,
                        input logic [79:0] wid, input logic [79:0] tv);
        cfg_start  = st;
        cfg_period = per;
        cfg_width  = wid;
        cfg_valid  = 1'b1;
        adv(tv);
        cfg_valid  = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_start  = '0;
        cfg_period = '0;
        cfg_width  = '0;
        ts_96      = '0;
        repeat (3) adv(t(9, 999_999_960));
        chk("rst_perout", perout, 0);
        chk("rst_locked", locked, 0);
        chk("rst_cfg_error", cfg_error, 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // 1 PPS with 8 ns ts steps around the edges
        load(t(10, 0), t(1, 0), t(0, 500_000_000), t(9, 999_999_960));
        for (int n = 999_999_968; n <= 999_999_992; n += 8) begin
            adv(t(9, n));
            chk("pps_pre", perout, 0);
        end
        adv(t(10, 0));
        chk("pps_one_clk", perout, 0);
        adv(t(10, 8));
        chk("pps_rise", perout, 1);
        chk("pps_locked", locked, 1);
        adv(t(10, 499_999_992));
        adv(t(10, 500_000_000));
        chk("pps_high", perout, 1);
        adv(t(10, 500_000_008));
        chk("pps_fall", perout, 0);
        adv(t(10, 999_999_992));
        adv(t(11, 0));
        chk("pps_low2", perout, 0);
        adv(t(11, 8));
        chk("pps_rise2", perout, 1);
        chk("pps_locked2", locked, 1);

        // ns carry: second rise at {6,500}, fall at {6,700}
        load(t(5, 999_999_000), t(0, 1_500), t(0, 200), t(5, 999_998_900));
        adv(t(5, 999_999_000));
        adv(t(5, 999_999_100));
        chk("carry_rise1", perout, 1);
        adv(t(5, 999_999_200));
        chk("carry_high1", perout, 1);
        adv(t(5, 999_999_300));
        chk("carry_fall1", perout, 0);
        chk("carry_locked1", locked, 1);
        adv(t(6, 400));
        chk("carry_low", perout, 0);
        chk("carry_locked_low", locked, 1);
        adv(t(6, 500));
        chk("carry_pre2", perout, 0);
        adv(t(6, 600));
        chk("carry_rise2", perout, 1);
        chk("carry_locked2", locked, 1);
        adv(t(6, 700));
        chk("carry_high2", perout, 1);
        adv(t(6, 800));
        chk("carry_fall2", perout, 0);

        // Illegal configs
        load(t(7, 0), t(0, 100), t(0, 100), t(6, 900));
        chk("ill_err", cfg_error, 1);
        chk("ill_perout", perout, 0);
        chk("ill_locked", locked, 0);
        adv(t(7, 0));
        adv(t(7, 50));
        adv(t(7, 100));
        chk("ill_idle", perout, 0);
        load(t(7, 1_000), t(0, 1_000), t(0, 100), t(7, 150));
        chk("ill_clear", cfg_error, 0);
        load(t(7, 2_000), t(0, 0), t(0, 0), t(7, 200));
        chk("ill_zero", cfg_error, 1);

        // 1 kHz then a +5 ms forward jump
        load(t(20, 0), t(0, 1_000_000), t(0, 100_000), t(19, 999_999_900));
        chk("fwd_err_clear", cfg_error, 0);
        adv(t(20, 0));
        adv(t(20, 100));
        chk("fwd_rise", perout, 1);
        adv(t(20, 100_000));
        adv(t(20, 100_100));
        chk("fwd_fall", perout, 0);
        adv(t(20, 5_100_100));
        chk("fwd_pre_locked", locked, 1);
        for (int k = 0; k < 4; k++) begin
            adv(t(20, 5_100_100));
            chk("fwd_catch_perout", perout, 0);
            chk("fwd_catch_locked", locked, 0);
        end
        adv(t(20, 5_100_100));
        chk("fwd_late_rise", perout, 1);
        chk("fwd_relock", locked, 1);
        adv(t(20, 5_100_100));
        chk("fwd_late_fall", perout, 0);
        adv(t(20, 5_999_900));
        adv(t(20, 6_000_000));
        chk("fwd_grid_pre", perout, 0);
        adv(t(20, 6_000_100));
        chk("fwd_grid_rise", perout, 1);
        chk("fwd_grid_locked", locked, 1);

        // Backward 2 s step while high
        adv(t(18, 6_000_200));
        chk("back_still_high", perout, 1);
        adv(t(18, 6_000_300));
        chk("back_perout", perout, 0);
        chk("back_locked", locked, 0);
        adv(t(19, 999_999_900));
        adv(t(20, 0));
        chk("back_pre", perout, 0);
        adv(t(20, 100));
        chk("back_resume", perout, 1);
        chk("back_relock", locked, 1);

        // Reset while high: config is gone afterwards
        rst_n = 1'b0;
        adv(t(20, 200));
        chk("mid_rst_perout", perout, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_err", cfg_error, 0);
        rst_n = 1'b1;
        adv(t(20, 1_000_000));
        adv(t(20, 1_000_100));
        adv(t(20, 1_000_200));
        chk("post_rst_quiet", perout, 0);

        // Enable drop while high
        load(t(30, 0), t(0, 1_000_000), t(0, 100_000), t(29, 999_999_900));
        adv(t(30, 0));
        adv(t(30, 100));
        chk("en_rise", perout, 1);
        enable = 1'b0;
        adv(t(30, 200));
        chk("en_drop", perout, 0);
        chk("en_drop_locked", locked, 0);
        adv(t(30, 1_000_000));
        adv(t(30, 1_000_100));
        chk("en_off_quiet", perout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
